// File: rtl/pending_encoder_32_5_pkg.sv
// pending_encoder_32_5_pkg: shared request-count and index-width constants for the pending encoder
package pending_encoder_32_5_pkg;
  localparam int ENC_N = 32;
  localparam int ENC_IDXW = 5;
endpackage

// File: rtl/pending_encoder_32_5_if.sv
// pending_encoder_32_5_if: request bus (set_valid/set_vec/clr_vec/rr_mode/out_ready in, out_valid/out_idx/pending/busy out); master drives requests, slave serves them
interface pending_encoder_32_5_if;
  import pending_encoder_32_5_pkg::*;
  logic set_valid;
  logic [ENC_N-1:0] set_vec;
  logic [ENC_N-1:0] clr_vec;
  logic rr_mode;
  logic out_valid;
  logic [ENC_IDXW-1:0] out_idx;
  logic out_ready;
  logic [ENC_N-1:0] pending;
  logic busy;
  modport master (output set_valid, set_vec, clr_vec, rr_mode, out_ready, input out_valid, out_idx, pending, busy);
  modport slave (input set_valid, set_vec, clr_vec, rr_mode, out_ready, output out_valid, out_idx, pending, busy);
endinterface

// File: rtl/pending_encoder_32_5_onehot_encoder.sv
// onehot_encoder_32_5: combinational one-hot (i_oh) to binary index (o_idx), inverse of decoder_5_32
module onehot_encoder_32_5
  import pending_encoder_32_5_pkg::*;
(
  input  logic [ENC_N-1:0]    i_oh,
  output logic [ENC_IDXW-1:0] o_idx
);
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < ENC_N; i++) o_idx = o_idx | (i_oh[i] ? ENC_IDXW'(i) : '0);
  end
endmodule

// File: rtl/pending_encoder_32_5.sv
// pending_encoder_32_5: pending-request register with fixed/round-robin selection into a one-entry output slot; ports clk, rst (async high), bus (slave)
module pending_encoder_32_5
  import pending_encoder_32_5_pkg::*;
#(
  parameter int N = ENC_N,
  parameter int IDXW = ENC_IDXW
) (
  input logic clk,
  input logic rst,
  pending_encoder_32_5_if.slave bus
);
  logic [N-1:0] r_pending, w_cand, w_rot, w_rot_sel, w_rr_oh, w_fix_oh, w_oh, w_taken;
  logic [IDXW-1:0] r_out_idx, r_ptr, w_k;
  logic r_out_valid, w_free, w_load;
  assign w_cand = r_pending & ~bus.clr_vec;
  assign w_free = ~r_out_valid | bus.out_ready;
  assign w_load = w_free & |w_cand;
  assign w_rot = (w_cand >> r_ptr) | (w_cand << (N - int'(r_ptr)));
  assign w_rot_sel = w_rot & -w_rot;
  assign w_rr_oh = (w_rot_sel << r_ptr) | (w_rot_sel >> (N - int'(r_ptr)));
  assign w_fix_oh = w_cand & -w_cand;
  assign w_oh = bus.rr_mode ? w_rr_oh : w_fix_oh;
  assign w_taken = w_load ? w_oh : '0;
  onehot_encoder_32_5 u_enc (.i_oh(w_oh), .o_idx(w_k));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_out_valid <= 1'b0;
      r_out_idx <= '0;
      r_ptr <= '0;
    end else begin
      r_pending <= ((r_pending & ~w_taken) | (bus.set_valid ? bus.set_vec : '0)) & ~bus.clr_vec;
      if (w_free) r_out_valid <= |w_cand;
      if (w_load) begin
        r_out_idx <= w_k;
        r_ptr <= w_k + IDXW'(1);
      end
    end
  end
  assign bus.pending = r_pending;
  assign bus.out_valid = r_out_valid;
  assign bus.out_idx = r_out_idx;
  assign bus.busy = |r_pending | r_out_valid;
endmodule

// File: tb/tb_pending_encoder_32_5.sv
// tb_pending_encoder_32_5: directed self-checking bench for pending_encoder_32_5
module tb_pending_encoder_32_5;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  pending_encoder_32_5_if intf ();
  pending_encoder_32_5 dut (.clk(clk), .rst(rst), .bus(intf));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic slot(input string tag, input logic v, input logic [4:0] idx);
    chk({tag, "_valid"}, 32'(intf.out_valid), 32'(v));
    if (v) chk({tag, "_idx"}, 32'(intf.out_idx), 32'(idx));
  endtask
  task automatic arm(input logic [31:0] v);
    intf.set_valid = 1'b1;
    intf.set_vec = v;
    tick();
    intf.set_valid = 1'b0;
    intf.set_vec = '0;
  endtask
  initial begin
    intf.set_valid = 1'b0;
    intf.set_vec = '0;
    intf.clr_vec = '0;
    intf.rr_mode = 1'b0;
    intf.out_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("rst_pending", intf.pending, 32'h0);
    chk("rst_valid", 32'(intf.out_valid), 32'h0);
    chk("rst_idx", 32'(intf.out_idx), 32'h0);
    chk("rst_busy", 32'(intf.busy), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    arm(32'h0000_0014);
    chk("fix_pending", intf.pending, 32'h0000_0014);
    chk("fix_latency", 32'(intf.out_valid), 32'h0);
    tick();
    slot("fix_first", 1'b1, 5'd2);
    chk("fix_pending2", intf.pending, 32'h0000_0010);
    tick();
    slot("fix_second", 1'b1, 5'd4);
    tick();
    slot("fix_idle", 1'b0, 5'd0);
    chk("fix_busy", 32'(intf.busy), 32'h0);
    arm(32'h4000_0000);
    intf.set_valid = 1'b1;
    intf.set_vec = 32'h8000_0001;
    tick();
    intf.set_valid = 1'b0;
    intf.set_vec = '0;
    slot("wrap_setup", 1'b1, 5'd30);
    chk("wrap_pending", intf.pending, 32'h8000_0001);
    intf.rr_mode = 1'b1;
    tick();
    slot("wrap_31", 1'b1, 5'd31);
    tick();
    slot("wrap_0", 1'b1, 5'd0);
    tick();
    slot("wrap_idle", 1'b0, 5'd0);
    arm(32'h0000_0005);
    tick();
    slot("rr_from1", 1'b1, 5'd2);
    tick();
    slot("rr_wrap", 1'b1, 5'd0);
    tick();
    arm(32'h0000_0005);
    intf.rr_mode = 1'b0;
    tick();
    slot("mode_switch", 1'b1, 5'd0);
    tick();
    slot("mode_next", 1'b1, 5'd2);
    tick();
    intf.out_ready = 1'b0;
    arm(32'h0000_0008);
    tick();
    slot("stall_load", 1'b1, 5'd3);
    intf.set_valid = 1'b1;
    intf.set_vec = 32'h1;
    for (int i = 0; i < 5; i++) begin
      tick();
      intf.set_valid = 1'b0;
      intf.set_vec = '0;
      slot("stall_hold", 1'b1, 5'd3);
    end
    chk("stall_pending", intf.pending, 32'h1);
    intf.out_ready = 1'b1;
    tick();
    slot("stall_after", 1'b1, 5'd0);
    tick();
    slot("stall_idle", 1'b0, 5'd0);
    arm(32'h0000_0280);
    intf.set_valid = 1'b1;
    intf.set_vec = 32'h80;
    intf.clr_vec = 32'h200;
    tick();
    intf.set_valid = 1'b0;
    intf.set_vec = '0;
    intf.clr_vec = '0;
    slot("prec_take", 1'b1, 5'd7);
    chk("prec_pending", intf.pending, 32'h80);
    tick();
    slot("prec_rearm", 1'b1, 5'd7);
    chk("prec_empty", intf.pending, 32'h0);
    tick();
    slot("prec_idle", 1'b0, 5'd0);
    intf.out_ready = 1'b0;
    arm(32'h20);
    tick();
    slot("clr_load", 1'b1, 5'd5);
    intf.clr_vec = 32'h20;
    tick();
    intf.clr_vec = '0;
    slot("clr_keep", 1'b1, 5'd5);
    intf.out_ready = 1'b1;
    tick();
    slot("clr_nodup", 1'b0, 5'd0);
    chk("clr_pending", intf.pending, 32'h0);
    intf.out_ready = 1'b0;
    arm(32'hFF);
    tick();
    slot("arst_setup", 1'b1, 5'd0);
    chk("arst_pend_setup", intf.pending, 32'hFE);
    #2 rst = 1'b1;
    #1;
    chk("arst_pending", intf.pending, 32'h0);
    chk("arst_valid", 32'(intf.out_valid), 32'h0);
    chk("arst_idx", 32'(intf.out_idx), 32'h0);
    chk("arst_busy", 32'(intf.busy), 32'h0);
    tick();
    rst = 1'b0;
    intf.rr_mode = 1'b1;
    intf.out_ready = 1'b1;
    arm(32'h0000_0081);
    tick();
    slot("arst_first", 1'b1, 5'd0);
    tick();
    slot("arst_second", 1'b1, 5'd7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
